// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter.
// Converts a W-bit unsigned value into D packed BCD digits with one shift per
// clock. The handshake is start/busy/done. bcd and digit_en hold the last
// completed result, and only the DONE edge or a reset changes them.
module bin2bcd_seq #(
    parameter int unsigned W = 10,
    parameter int unsigned D = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic [4*D-1:0]   bcd,
    output logic [D-1:0]     digit_en
);

    localparam int unsigned   CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);
    localparam logic [D-1:0]  EN_RESET = D'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [4*D-1:0]  scratch_q, scratch_d;
    logic [4*D-1:0]  scratch_adj;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4*D-1:0]  bcd_q, bcd_d;
    logic [D-1:0]    en_q, en_d;
    logic            done_q, done_d;

    // A digit is shown if it or any more significant digit is non-zero.
    // The units digit is always shown, so the value 0 displays as "0".
    function automatic logic [D-1:0] lead_mask(input logic [4*D-1:0] v);
        logic [D-1:0] m;
        logic         seen;
        int unsigned  idx;
        m    = '0;
        seen = 1'b0;
        for (int unsigned i = 0; i < D; i++) begin
            idx    = D - 1 - i;
            seen   = seen | (v[4*idx +: 4] != 4'd0);
            m[idx] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    // Add-3 correction: any scratch digit >= 5 gets +3, all digits in parallel.
    // The sum stays inside its own nibble.
    always_comb begin
        scratch_adj = scratch_q;
        for (int unsigned k = 0; k < D; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // FSM next-state logic and datapath updates.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        en_d      = en_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CNT_LOAD;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // The shift MSB enters the corrected scratch LSB. The shift LSB fills with 0.
                {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
                cnt_d = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = scratch_q;
                en_d    = lead_mask(scratch_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset is synchronous and discards any in-flight conversion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            en_q      <= EN_RESET;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            en_q      <= en_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q == SHIFT) || (state_q == DONE);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign digit_en = en_q;

endmodule
